// File: rtl/serdes_pkg.sv
// Shared definitions for the TMDS receive path: control-token table, aligner states
// and the token matcher used for word alignment.
package serdes_pkg;

    localparam int unsigned TOKEN_WIDTH = 10;
    localparam int unsigned NUM_TOKENS  = 4;

    localparam logic [TOKEN_WIDTH-1:0] TMDS_CTRL_TOKENS [NUM_TOKENS] = '{
        10'h354, 10'h0AB, 10'h154, 10'h2AB
    };

    typedef enum logic [1:0] {
        ALIGN_SEARCH,
        ALIGN_VERIFY,
        ALIGN_LOCKED
    } align_state_e;

    function automatic logic is_ctrl_token(input logic [TOKEN_WIDTH-1:0] word);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_TOKENS; i++) begin
            if (word == TMDS_CTRL_TOKENS[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/word_aligner.sv
// Single-lane word builder: shifts serial bits into a 2W window, extracts a word at the
// current slip offset once per word period and bit-slips until control tokens line up.
module word_aligner
    import serdes_pkg::*;
#(
    parameter int unsigned BPC          = 2,
    parameter int unsigned WORD_WIDTH   = 10,
    parameter bit          LSB_FIRST    = 1'b1,
    parameter int unsigned SEARCH_WORDS = 4,
    parameter int unsigned LOCK_HITS    = 8,
    parameter int unsigned LOSS_WORDS   = 4096,
    localparam int unsigned SLIP_W      = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [BPC-1:0]        bits_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  word_valid_o,
    output logic                  locked_o,
    output logic [SLIP_W-1:0]     slip_o
);

    localparam int unsigned WIN_W  = 2 * WORD_WIDTH;
    localparam int unsigned BEATS  = WORD_WIDTH / BPC;
    localparam int unsigned BEAT_W = $clog2(BEATS + 1);
    localparam int unsigned MISS_W = $clog2(SEARCH_WORDS + 1);
    localparam int unsigned HIT_W  = $clog2(LOCK_HITS + 1);
    localparam int unsigned LOSS_W = $clog2(LOSS_WORDS + 1);

    if ((WORD_WIDTH % BPC) != 0) begin : g_width_check
        $error("WORD_WIDTH must be a multiple of the bits delivered per clock");
    end

    logic [WIN_W-1:0]      window, window_next;
    logic [BEAT_W-1:0]     beat_cnt, beat_next;
    logic [SLIP_W-1:0]     slip, slip_next;
    logic [MISS_W-1:0]     miss_cnt, miss_next;
    logic [HIT_W-1:0]      hit_cnt, hit_next;
    logic [LOSS_W-1:0]     loss_cnt, loss_next;
    align_state_e          state, state_next;
    logic [WORD_WIDTH-1:0] slice, word_cand, word_next;
    logic                  valid_next;
    logic                  word_end;
    logic                  match;

    assign word_end = (beat_cnt == BEAT_W'(BEATS - 1));

    // Newest bit sits at index 0, so a larger slip reaches further back in time.
    always_comb begin
        window_next = {window[WIN_W-BPC-1:0], {BPC{1'b0}}};
        for (int k = 0; k < BPC; k++) begin
            window_next[BPC-1-k] = bits_i[k];
        end
        slice     = WORD_WIDTH'(window_next >> slip);
        word_cand = '0;
        for (int j = 0; j < WORD_WIDTH; j++) begin
            word_cand[j] = LSB_FIRST ? slice[WORD_WIDTH-1-j] : slice[j];
        end
    end

    if (WORD_WIDTH == TOKEN_WIDTH) begin : g_token_match
        assign match = is_ctrl_token(word_cand);
    end else begin : g_no_token_match
        assign match = 1'b0;
    end

    always_comb begin
        state_next = state;
        slip_next  = slip;
        miss_next  = miss_cnt;
        hit_next   = hit_cnt;
        loss_next  = loss_cnt;
        beat_next  = beat_cnt;
        word_next  = word_o;
        valid_next = 1'b0;
        if (enable_i) begin
            beat_next = word_end ? '0 : beat_cnt + BEAT_W'(1);
            if (word_end) begin
                word_next  = word_cand;
                valid_next = 1'b1;
                unique case (state)
                    ALIGN_SEARCH: begin
                        if (match) begin
                            state_next = (LOCK_HITS <= 1) ? ALIGN_LOCKED : ALIGN_VERIFY;
                            hit_next   = HIT_W'(1);
                            miss_next  = '0;
                        end else if (miss_cnt == MISS_W'(SEARCH_WORDS - 1)) begin
                            slip_next = (slip == SLIP_W'(WORD_WIDTH - 1)) ? '0
                                                                          : slip + SLIP_W'(1);
                            miss_next = '0;
                        end else begin
                            miss_next = miss_cnt + MISS_W'(1);
                        end
                    end
                    ALIGN_VERIFY: begin
                        if (!match) begin
                            state_next = ALIGN_SEARCH;
                            hit_next   = '0;
                            miss_next  = '0;
                        end else if (hit_cnt >= HIT_W'(LOCK_HITS - 1)) begin
                            state_next = ALIGN_LOCKED;
                            hit_next   = '0;
                        end else begin
                            hit_next = hit_cnt + HIT_W'(1);
                        end
                    end
                    ALIGN_LOCKED: begin
                        if (match) begin
                            loss_next = '0;
                        end else if (loss_cnt >= LOSS_W'(LOSS_WORDS - 1)) begin
                            // Reaching the limit drops lock, so the counter never wraps.
                            state_next = ALIGN_SEARCH;
                            loss_next  = '0;
                            miss_next  = '0;
                            hit_next   = '0;
                        end else begin
                            loss_next = loss_cnt + LOSS_W'(1);
                        end
                    end
                    default: begin
                        state_next = ALIGN_SEARCH;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            window       <= '0;
            beat_cnt     <= '0;
            slip         <= '0;
            miss_cnt     <= '0;
            hit_cnt      <= '0;
            loss_cnt     <= '0;
            state        <= ALIGN_SEARCH;
            word_o       <= '0;
            word_valid_o <= 1'b0;
        end else begin
            if (enable_i) begin
                window <= window_next;
            end
            beat_cnt     <= beat_next;
            slip         <= slip_next;
            miss_cnt     <= miss_next;
            hit_cnt      <= hit_next;
            loss_cnt     <= loss_next;
            state        <= state_next;
            word_o       <= word_next;
            word_valid_o <= valid_next;
        end
    end

    assign locked_o = (state == ALIGN_LOCKED);
    assign slip_o   = slip;

endmodule

// File: rtl/generic_deserializer.sv
// N-lane serial-to-parallel receiver in the fast clock domain; each lane aligns
// independently through its own word_aligner.
module generic_deserializer
    import serdes_pkg::*;
#(
    parameter bit          DDRIO            = 1'b1,
    parameter int unsigned NUM_PHY_CHANNELS = 4,
    parameter int unsigned WORD_WIDTH       = 10,
    parameter bit          LSB_FIRST        = 1'b1,
    parameter int unsigned SEARCH_WORDS     = 4,
    parameter int unsigned LOCK_HITS        = 8,
    parameter int unsigned LOSS_WORDS       = 4096,
    localparam int unsigned BPC             = DDRIO ? 2 : 1,
    localparam int unsigned SLIP_W          = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        enable_i,
    input  logic [NUM_PHY_CHANNELS-1:0][BPC-1:0]        bits_i,
    output logic [NUM_PHY_CHANNELS-1:0][WORD_WIDTH-1:0] word_o,
    output logic [NUM_PHY_CHANNELS-1:0]                 word_valid_o,
    output logic [NUM_PHY_CHANNELS-1:0]                 locked_o,
    output logic [NUM_PHY_CHANNELS-1:0][SLIP_W-1:0]     slip_o
);

    for (genvar ch = 0; ch < NUM_PHY_CHANNELS; ch++) begin : g_lane
        word_aligner #(
            .BPC          (BPC),
            .WORD_WIDTH   (WORD_WIDTH),
            .LSB_FIRST    (LSB_FIRST),
            .SEARCH_WORDS (SEARCH_WORDS),
            .LOCK_HITS    (LOCK_HITS),
            .LOSS_WORDS   (LOSS_WORDS)
        ) u_aligner (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .enable_i     (enable_i),
            .bits_i       (bits_i[ch]),
            .word_o       (word_o[ch]),
            .word_valid_o (word_valid_o[ch]),
            .locked_o     (locked_o[ch]),
            .slip_o       (slip_o[ch])
        );
    end

endmodule

// File: tb/tb_generic_deserializer.sv
// Directed bench: DDR and SDR deserializers fed from bit queues; lane 2 of the DDR
// instance only ever sees zeros, so it must never lock while the other lanes do.
module tb_generic_deserializer;

    localparam int unsigned N = 4;
    localparam int unsigned W = 10;
    localparam logic [N-1:0] LOCK_DDR = 4'b1011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic en    = 1'b1;

    logic [N-1:0][1:0]   bits_d = '0;
    logic [N-1:0][0:0]   bits_s = '0;
    logic [N-1:0][W-1:0] word_d, word_s;
    logic [N-1:0]        valid_d, valid_s, locked_d, locked_s;
    logic [N-1:0][3:0]   slip_d, slip_s;

    int total = 0;
    int bad   = 0;
    bit qd[$];
    bit qs[$];

    generic_deserializer #(
        .DDRIO(1'b1), .NUM_PHY_CHANNELS(N), .WORD_WIDTH(W), .LSB_FIRST(1'b1),
        .SEARCH_WORDS(4), .LOCK_HITS(8), .LOSS_WORDS(16)
    ) u_ddr (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .bits_i(bits_d),
        .word_o(word_d), .word_valid_o(valid_d), .locked_o(locked_d), .slip_o(slip_d)
    );

    generic_deserializer #(
        .DDRIO(1'b0), .NUM_PHY_CHANNELS(N), .WORD_WIDTH(W), .LSB_FIRST(1'b1),
        .SEARCH_WORDS(4), .LOCK_HITS(8), .LOSS_WORDS(16)
    ) u_sdr (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .bits_i(bits_s),
        .word_o(word_s), .word_valid_o(valid_s), .locked_o(locked_s), .slip_o(slip_s)
    );

    // Bits leave the queues only while enabled, so the serial stream stays contiguous.
    task automatic tick();
        logic b0, b1, s0;
        b0 = 1'b0; b1 = 1'b0; s0 = 1'b0;
        if (en) begin
            if (qd.size() > 0) b0 = qd.pop_front();
            if (qd.size() > 0) b1 = qd.pop_front();
            if (qs.size() > 0) s0 = qs.pop_front();
        end
        for (int ch = 0; ch < N; ch++) begin
            bits_d[ch] = (ch == 2) ? 2'b00 : {b1, b0};
            bits_s[ch] = s0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_d(input logic [W-1:0] w, input int n);
        repeat (n) for (int j = 0; j < W; j++) qd.push_back(w[j]);
    endtask

    task automatic push_s(input logic [W-1:0] w, input int n);
        repeat (n) for (int j = 0; j < W; j++) qs.push_back(w[j]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        qd.delete();
        qs.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid_d(input int max_cyc, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < max_cyc) begin
            tick();
            cyc++;
            if (valid_d[0]) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        qd.delete();
        qs.delete();
        for (int i = 0; i < 3; i++) begin
            repeat (2) qd.push_back(bit'($urandom_range(1, 0)));
            qs.push_back(bit'($urandom_range(1, 0)));
            tick();
            total++;
            if (valid_d !== '0 || valid_s !== '0) begin
                bad++;
                $display("FAIL reset_valid cyc=%0d got %b/%b required 0", i, valid_d, valid_s);
            end
            total++;
            if (locked_d !== '0 || locked_s !== '0) begin
                bad++;
                $display("FAIL reset_locked cyc=%0d got %b/%b required 0", i, locked_d, locked_s);
            end
            total++;
            if (word_d !== '0 || word_s !== '0) begin
                bad++;
                $display("FAIL reset_word cyc=%0d got %h/%h required 0", i, word_d, word_s);
            end
            total++;
            if (slip_d !== '0 || slip_s !== '0) begin
                bad++;
                $display("FAIL reset_slip cyc=%0d got %h/%h required 0", i, slip_d, slip_s);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_aligned();
        int n;
        logic [N-1:0] exp_valid;
        n = 0;
        do_reset();
        push_d(10'h354, 12);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            tick();
            exp_valid = (cyc % 5 == 0) ? 4'hF : 4'h0;
            total++;
            if (valid_d !== exp_valid) begin
                bad++;
                $display("FAIL aligned_valid cyc=%0d got %b required %b", cyc, valid_d, exp_valid);
            end
            if (valid_d[0]) begin
                n++;
                total++;
                if (word_d[0] !== 10'h354) begin
                    bad++;
                    $display("FAIL aligned_word n=%0d got %h required 354", n, word_d[0]);
                end
                total++;
                if (locked_d !== ((n >= 8) ? LOCK_DDR : 4'b0000)) begin
                    bad++;
                    $display("FAIL aligned_locked n=%0d got %b required %b", n, locked_d,
                             (n >= 8) ? LOCK_DDR : 4'b0000);
                end
            end
        end
        total++;
        if (slip_d[0] !== 4'd0 || n != 12) begin
            bad++;
            $display("FAIL aligned_end got slip=%0d words=%0d required slip=0 words=12",
                     slip_d[0], n);
        end
    endtask

    // Seven filler bits leave every token ending three bits before the word boundary.
    task automatic test_slip3();
        int cyc;
        bit seen;
        do_reset();
        repeat (7) qd.push_back(1'b0);
        push_d(10'h354, 22);
        for (int k = 1; k <= 20; k++) begin
            wait_valid_d(6, cyc, seen);
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL slip_timeout word=%0d got no valid required valid within 6 clk", k);
                return;
            end
            if (k % 4 == 0 && k <= 12) begin
                total++;
                if (slip_d[0] !== 4'(k / 4)) begin
                    bad++;
                    $display("FAIL slip_step word=%0d got %0d required %0d", k, slip_d[0], k / 4);
                end
            end
            if (k == 19) begin
                total++;
                if (locked_d !== 4'b0000) begin
                    bad++;
                    $display("FAIL slip_early_lock got %b required 0000", locked_d);
                end
            end
        end
        total++;
        if (locked_d !== LOCK_DDR || word_d[0] !== 10'h354 || slip_d[0] !== 4'd3) begin
            bad++;
            $display("FAIL slip_lock got locked=%b word=%h slip=%0d required %b 354 3",
                     locked_d, word_d[0], slip_d[0], LOCK_DDR);
        end
    endtask

    task automatic test_loss();
        int cyc;
        bit seen;
        do_reset();
        push_d(10'h354, 8);
        push_d(10'h1F0, 15);
        push_d(10'h0AB, 1);
        push_d(10'h1F0, 16);
        for (int k = 1; k <= 40; k++) begin
            wait_valid_d(6, cyc, seen);
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL loss_timeout word=%0d got no valid required valid within 6 clk", k);
                return;
            end
            case (k)
                8, 23, 39: begin
                    total++;
                    if (locked_d !== LOCK_DDR) begin
                        bad++;
                        $display("FAIL loss_hold word=%0d got %b required %b", k, locked_d, LOCK_DDR);
                    end
                end
                24: begin
                    total++;
                    if (locked_d !== LOCK_DDR || word_d[0] !== 10'h0AB) begin
                        bad++;
                        $display("FAIL loss_token got locked=%b word=%h required %b 0ab",
                                 locked_d, word_d[0], LOCK_DDR);
                    end
                end
                40: begin
                    total++;
                    if (locked_d !== 4'b0000 || word_d[0] !== 10'h1F0) begin
                        bad++;
                        $display("FAIL loss_drop got locked=%b word=%h required 0000 1f0",
                                 locked_d, word_d[0]);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_enable_gap();
        int cyc;
        bit seen;
        do_reset();
        push_d(10'h354, 14);
        for (int k = 1; k <= 8; k++) wait_valid_d(6, cyc, seen);
        total++;
        if (locked_d !== LOCK_DDR) begin
            bad++;
            $display("FAIL gap_prelock got %b required %b", locked_d, LOCK_DDR);
        end
        tick();
        tick();
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            total++;
            if (valid_d !== '0 || locked_d !== LOCK_DDR || word_d[0] !== 10'h354) begin
                bad++;
                $display("FAIL gap_hold cyc=%0d got valid=%b locked=%b word=%h required 0 %b 354",
                         i, valid_d, locked_d, word_d[0], LOCK_DDR);
            end
        end
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (valid_d !== ((i == 3) ? 4'hF : 4'h0)) begin
                bad++;
                $display("FAIL gap_resume cyc=%0d got %b required %b", i, valid_d,
                         (i == 3) ? 4'hF : 4'h0);
            end
        end
        total++;
        if (word_d[0] !== 10'h354 || locked_d !== LOCK_DDR) begin
            bad++;
            $display("FAIL gap_word got word=%h locked=%b required 354 %b",
                     word_d[0], locked_d, LOCK_DDR);
        end
    endtask

    task automatic test_reset_midlock();
        int cyc;
        bit seen;
        do_reset();
        push_d(10'h354, 10);
        for (int k = 1; k <= 8; k++) wait_valid_d(6, cyc, seen);
        total++;
        if (locked_d !== LOCK_DDR) begin
            bad++;
            $display("FAIL rst_prelock got %b required %b", locked_d, LOCK_DDR);
        end
        rst_n = 1'b0;
        qd.delete();
        tick();
        total++;
        if (locked_d !== '0 || slip_d !== '0 || valid_d !== '0 || word_d !== '0) begin
            bad++;
            $display("FAIL rst_pulse got locked=%b slip=%h valid=%b word=%h required all 0",
                     locked_d, slip_d, valid_d, word_d);
        end
        rst_n = 1'b1;
        push_d(10'h354, 8);
        for (int k = 1; k <= 8; k++) begin
            wait_valid_d(6, cyc, seen);
            total++;
            if (!seen || cyc != 5) begin
                bad++;
                $display("FAIL rst_cadence word=%0d got %0d clk required 5", k, cyc);
            end
            if (k >= 7) begin
                total++;
                if (locked_d !== ((k == 8) ? LOCK_DDR : 4'b0000)) begin
                    bad++;
                    $display("FAIL rst_relock word=%0d got %b required %b", k, locked_d,
                             (k == 8) ? LOCK_DDR : 4'b0000);
                end
            end
        end
    endtask

    task automatic test_sdr();
        int n;
        logic [N-1:0] exp_valid;
        n = 0;
        do_reset();
        push_s(10'h354, 9);
        for (int cyc = 1; cyc <= 90; cyc++) begin
            tick();
            exp_valid = (cyc % 10 == 0) ? 4'hF : 4'h0;
            total++;
            if (valid_s !== exp_valid) begin
                bad++;
                $display("FAIL sdr_valid cyc=%0d got %b required %b", cyc, valid_s, exp_valid);
            end
            if (valid_s[0]) begin
                n++;
                total++;
                if (word_s[0] !== 10'h354 || locked_s !== ((n >= 8) ? 4'hF : 4'h0)) begin
                    bad++;
                    $display("FAIL sdr_word n=%0d got word=%h locked=%b required 354 %b", n,
                             word_s[0], locked_s, (n >= 8) ? 4'hF : 4'h0);
                end
            end
        end
        total++;
        if (slip_s !== '0) begin
            bad++;
            $display("FAIL sdr_slip got %h required 0", slip_s);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_slip3();
        test_loss();
        test_enable_gap();
        test_reset_midlock();
        test_sdr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish required finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
